// File: rtl/serial_alu.sv
// serial_alu: pushbutton-driven serial ALU.
//   Two raw pushbuttons are synchronized, debounced and edge-detected.
//   A shift press clocks si into operand A; an exec press runs the
//   operation selected by mode against operand B.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   btn_shift raw pushbutton, shifts si into a_reg
//   btn_exec  raw pushbutton, executes mode
//   si        serial bit for operand A
//   b         operand B (WIDTH bits)
//   mode      00 add, 01 sub, 10 accumulate, 11 clear
//   a_reg     current operand A
//   result    last operation result
//   carry     carry-out (add/acc) or no-borrow (sub)
//   ov        two's-complement overflow of last operation
//   valid     one-cycle strobe when result/carry/ov update
module serial_alu #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_shift,
    input  logic             btn_exec,
    input  logic             si,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ov,
    output logic             valid
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    // index 0 = shift button, index 1 = exec button
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] db_level;
    logic [1:0] db_prev;
    logic [1:0] pulse;

    assign btn_raw = {btn_exec, btn_shift};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [CW-1:0] db_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1[i]    <= 1'b0;
                sync2[i]    <= 1'b0;
                db_cnt      <= '0;
                db_level[i] <= 1'b0;
                db_prev[i]  <= 1'b0;
            end else begin
                sync1[i]   <= btn_raw[i];
                sync2[i]   <= sync1[i];
                db_prev[i] <= db_level[i];
                // count only while the synchronized input disagrees with the
                // accepted level; any agreement restarts the stability window
                if (sync2[i] == db_level[i]) begin
                    db_cnt <= '0;
                end else if (db_cnt == CNT_TC) begin
                    db_level[i] <= sync2[i];
                    db_cnt      <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    // rising edge of the debounced level only; release makes no pulse
    assign pulse = db_level & ~db_prev;

    logic             shift_pulse;
    logic             exec_pulse;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ov_calc;

    assign shift_pulse = pulse[0];
    assign exec_pulse  = pulse[1];

    // Subtract is A + ~B + 1, so the add overflow rule applied to the
    // inverted operand gives the subtract rule directly.
    always_comb begin
        op_a    = (mode == MODE_ACC) ? acc : a_reg;
        op_b    = (mode == MODE_SUB) ? ~b : b;
        cin     = (mode == MODE_SUB);
        sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        ov_calc = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            acc    <= '0;
            result <= '0;
            carry  <= 1'b0;
            ov     <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= exec_pulse;
            if (shift_pulse) begin
                a_reg <= {a_reg[WIDTH-2:0], si};
            end
            // op_a was taken from the pre-shift a_reg; clear is written last
            // so it overrides a simultaneous shift
            if (exec_pulse) begin
                if (mode == MODE_CLR) begin
                    a_reg  <= '0;
                    acc    <= '0;
                    result <= '0;
                    carry  <= 1'b0;
                    ov     <= 1'b0;
                end else begin
                    result <= sum[WIDTH-1:0];
                    carry  <= sum[WIDTH];
                    ov     <= ov_calc;
                    if (mode == MODE_ACC) begin
                        acc <= sum[WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: table-driven directed vectors, hand-written corner
// sequences and randomized presses checked against an arithmetic model.
module tb_serial_alu;

    localparam int W    = 4;
    localparam int DB   = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int MASK = MOD - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_shift;
    logic         btn_exec;
    logic         si;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic [W-1:0] a_reg;
    logic [W-1:0] result;
    logic         carry;
    logic         ov;
    logic         valid;

    int tests = 0;
    int fails = 0;

    int m_a, m_acc, m_res, m_c, m_ov;

    serial_alu #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_shift (btn_shift),
        .btn_exec  (btn_exec),
        .si        (si),
        .b         (b),
        .mode      (mode),
        .a_reg     (a_reg),
        .result    (result),
        .carry     (carry),
        .ov        (ov),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sh;
        bit ex;
        int s;
        int bb;
        int md;
        int ea;
        int er;
        int ec;
        int eov;
    } vec_t;

    vec_t vecs[13];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    // Model: operands as plain integers, overflow from signed range.
    task automatic model_apply(input bit sh, input bit ex, input int s,
                               input int bb, input int md);
        int pre_a, sum, sx;
        pre_a = m_a;
        if (sh) m_a = ((m_a << 1) | s) & MASK;
        if (ex) begin
            sum = 0;
            sx  = 0;
            case (md)
                0: begin sum = pre_a + bb;       sx = sgn(pre_a) + sgn(bb); end
                1: begin sum = pre_a - bb + MOD; sx = sgn(pre_a) - sgn(bb); end
                2: begin sum = m_acc + bb;       sx = sgn(m_acc) + sgn(bb); end
                default: ;
            endcase
            if (md == 3) begin
                m_a = 0; m_acc = 0; m_res = 0; m_c = 0; m_ov = 0;
            end else begin
                m_res = sum % MOD;
                m_c   = (sum >= MOD) ? 1 : 0;
                m_ov  = (sx < -HALF || sx > HALF - 1) ? 1 : 0;
                if (md == 2) m_acc = m_res;
            end
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_acc = 0; m_res = 0; m_c = 0; m_ov = 0;
    endtask

    // Clean press and release; returns number of valid cycles seen.
    task automatic press(input bit sh, input bit ex, input int s,
                         input int bb, input int md, output int vcnt);
        si        = s[0];
        b         = W'(bb);
        mode      = 2'(md);
        btn_shift = sh;
        btn_exec  = ex;
        vcnt      = 0;
        repeat (12) begin
            cyc();
            if (valid) vcnt++;
        end
        btn_shift = 1'b0;
        btn_exec  = 1'b0;
        repeat (12) begin
            cyc();
            if (valid) vcnt++;
        end
    endtask

    task automatic check_model(input string tag, input int vcnt, input bit ex);
        check({tag, " a_reg"},  int'(a_reg),  m_a);
        check({tag, " result"}, int'(result), m_res);
        check({tag, " carry"},  int'(carry),  m_c);
        check({tag, " ov"},     int'(ov),     m_ov);
        check({tag, " valid"},  vcnt,         ex ? 1 : 0);
    endtask

    initial begin
        int vcnt;

        //            sh ex s  b  md  a   res c ov
        vecs[0]  = '{1, 0, 0, 0, 0,  0,  0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0,  1,  0, 0, 0};
        vecs[2]  = '{1, 0, 1, 0, 0,  3,  0, 0, 0};
        vecs[3]  = '{0, 1, 0, 5, 0,  3,  8, 0, 1};
        vecs[4]  = '{0, 1, 0, 5, 1,  3, 14, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 3,  0,  0, 0, 0};
        vecs[6]  = '{0, 1, 0, 7, 2,  0,  7, 0, 0};
        vecs[7]  = '{0, 1, 0, 7, 2,  0, 14, 0, 1};
        vecs[8]  = '{1, 0, 1, 0, 0,  1, 14, 0, 1};
        vecs[9]  = '{1, 1, 1, 1, 0,  3,  2, 0, 0};
        vecs[10] = '{1, 1, 1, 9, 2,  7,  7, 1, 1};
        vecs[11] = '{1, 1, 1, 0, 3,  0,  0, 0, 0};
        vecs[12] = '{0, 1, 0, 0, 1,  0,  0, 1, 0};

        rst_n     = 1'b0;
        btn_shift = 1'b0;
        btn_exec  = 1'b0;
        si        = 1'b0;
        b         = '0;
        mode      = 2'b00;
        model_reset();
        #2;
        check("initial reset a_reg", int'(a_reg), 0);
        check("initial reset valid", int'(valid), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        for (int i = 0; i < 13; i++) begin
            press(vecs[i].sh, vecs[i].ex, vecs[i].s, vecs[i].bb, vecs[i].md, vcnt);
            model_apply(vecs[i].sh, vecs[i].ex, vecs[i].s, vecs[i].bb, vecs[i].md);
            check($sformatf("vec%0d a_reg", i),  int'(a_reg),  vecs[i].ea);
            check($sformatf("vec%0d result", i), int'(result), vecs[i].er);
            check($sformatf("vec%0d carry", i),  int'(carry),  vecs[i].ec);
            check($sformatf("vec%0d ov", i),     int'(ov),     vecs[i].eov);
            check($sformatf("vec%0d valid", i),  vcnt,         vecs[i].ex ? 1 : 0);
        end

        // Asynchronous reset with no clock edge: load nonzero state first.
        press(1, 0, 1, 0, 0, vcnt);
        model_apply(1, 0, 1, 0, 0);
        press(0, 1, 0, 7, 0, vcnt);
        model_apply(0, 1, 0, 7, 0);
        check_model("pre-reset", vcnt, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset a_reg",  int'(a_reg),  0);
        check("async reset result", int'(result), 0);
        check("async reset carry",  int'(carry),  0);
        check("async reset ov",     int'(ov),     0);
        check("async reset valid",  int'(valid),  0);
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Bounce rejection; mode=clear so an accepted exec would be visible.
        press(1, 0, 1, 0, 0, vcnt);
        model_apply(1, 0, 1, 0, 0);
        press(0, 1, 0, 2, 0, vcnt);
        model_apply(0, 1, 0, 2, 0);
        check_model("bounce setup", vcnt, 1);
        mode = 2'b11;
        b    = 4'hF;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            btn_exec = 1'b1;
            repeat (2) begin cyc(); if (valid) vcnt++; end
            btn_exec = 1'b0;
            repeat (2) begin cyc(); if (valid) vcnt++; end
        end
        btn_exec = 1'b1;
        repeat (3) begin cyc(); if (valid) vcnt++; end
        btn_exec = 1'b0;
        repeat (15) begin cyc(); if (valid) vcnt++; end
        check_model("bounce", vcnt, 0);

        // Reset mid-debounce: counter one step from acceptance, then reset.
        si        = 1'b1;
        mode      = 2'b00;
        b         = 4'h1;
        btn_shift = 1'b1;
        btn_exec  = 1'b1;
        repeat (5) cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        vcnt  = 0;
        repeat (2) begin cyc(); if (valid) vcnt++; end
        btn_shift = 1'b0;
        btn_exec  = 1'b0;
        repeat (20) begin cyc(); if (valid) vcnt++; end
        check_model("reset mid-debounce", vcnt, 0);
        press(1, 0, 1, 0, 0, vcnt);
        model_apply(1, 0, 1, 0, 0);
        check_model("after reset press", vcnt, 0);

        // Randomized presses against the model.
        for (int n = 0; n < 30; n++) begin
            int r, s, bb, md;
            bit sh, ex;
            r  = int'($urandom_range(1, 3));
            sh = r[0];
            ex = r[1];
            s  = int'($urandom_range(0, 1));
            bb = int'($urandom_range(0, MASK));
            md = int'($urandom_range(0, 3));
            press(sh, ex, s, bb, md, vcnt);
            model_apply(sh, ex, s, bb, md);
            check_model($sformatf("rand%0d", n), vcnt, ex);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
